// File: rtl/stream_arb_pkg.sv
// Shared defaults and helpers for the round-robin stream arbiter.
// Packet locking is enabled in the arbiter by defining STREAM_ARB_PKT_LOCK_EN.
package stream_arb_pkg;

   localparam int unsigned NUM_REQ_DEF    = 4;
   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned ID_WIDTH_DEF   = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;

   typedef logic [ID_WIDTH_DEF-1:0] id_t;

   // Requester index after id, wrapping back to 0 past the last requester
   function automatic int unsigned next_ptr(input int unsigned id,
                                            input int unsigned num_req = NUM_REQ_DEF);
      return (id >= num_req - 1) ? 0 : id + 1;
   endfunction

endpackage

// File: rtl/rr_grant_mask.sv
// Combinational round-robin pick: first asserted req at or above ptr, wrapping.
// Produces a one-hot grant and the matching index; reusable by other arbiters.
module rr_grant_mask #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] idx;
   logic          found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = IW'((32'(ptr) + k) % N);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready stage among NUM_REQ streams.
// Define STREAM_ARB_PKT_LOCK_EN to add req_last/out_last and hold the grant for a whole packet.
module stream_rr_arbiter
   import stream_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ    = NUM_REQ_DEF,
   parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   localparam int unsigned ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef STREAM_ARB_PKT_LOCK_EN
   input  logic [NUM_REQ-1:0]            req_last,
   output logic                          out_last,
`endif
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [ID_WIDTH-1:0]           out_id
);

   logic [ID_WIDTH-1:0]   ptr;
   logic [ID_WIDTH-1:0]   rr_idx;
   logic [ID_WIDTH-1:0]   g_idx;
   logic [NUM_REQ-1:0]    rr_grant;
   logic [NUM_REQ-1:0]    grant;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  load;
   logic                  accept;

   rr_grant_mask #(
      .N  (NUM_REQ),
      .IW (ID_WIDTH)
   ) u_grant (
      .req       (req_valid),
      .ptr       (ptr),
      .grant     (rr_grant),
      .grant_idx (rr_idx)
   );

`ifdef STREAM_ARB_PKT_LOCK_EN
   logic                lock;
   logic [ID_WIDTH-1:0] lock_id;

   // Mid-packet the grant stays on the owning requester, even while it is idle
   always_comb begin
      grant = rr_grant;
      g_idx = rr_idx;
      if (lock) begin
         grant          = '0;
         grant[lock_id] = 1'b1;
         g_idx          = lock_id;
      end
   end
`else
   assign grant = rr_grant;
   assign g_idx = rr_idx;
`endif

   assign load      = ~out_valid | out_ready;
   assign req_ready = grant & {NUM_REQ{rst_n & load}};
   assign accept    = |(req_valid & req_ready);
   assign sel_data  = req_data[32'(g_idx)*DATA_WIDTH +: DATA_WIDTH];

   // Output register plus priority/lock state; priority only moves on an accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         ptr       <= '0;
`ifdef STREAM_ARB_PKT_LOCK_EN
         out_last  <= 1'b0;
         lock      <= 1'b0;
         lock_id   <= '0;
`endif
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_id    <= g_idx;
`ifdef STREAM_ARB_PKT_LOCK_EN
         out_last  <= req_last[g_idx];
         lock      <= ~req_last[g_idx];
         lock_id   <= g_idx;
         if (req_last[g_idx]) begin
            ptr <= ID_WIDTH'(next_ptr(32'(g_idx), NUM_REQ));
         end
`else
         ptr       <= ID_WIDTH'(next_ptr(32'(g_idx), NUM_REQ));
`endif
      end else if (out_valid & out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed cases then randomized traffic
// against a behavioural model (honours STREAM_ARB_PKT_LOCK_EN when defined).
module tb_stream_rr_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned IW = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_data;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data;
   logic [IW-1:0]  out_id;
`ifdef STREAM_ARB_PKT_LOCK_EN
   logic [N-1:0]   req_last;
   logic           out_last;
`endif

   always #5 clk = ~clk;

   stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
`ifdef STREAM_ARB_PKT_LOCK_EN
      .req_last  (req_last),
      .out_last  (out_last),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id)
   );

   int n_vec = 0;
   int n_err = 0;

   // Behavioural view of the arbiter: held beat, priority pointer, packet owner
   bit         m_valid;
   logic [W-1:0] m_data;
   int         m_id;
   bit         m_last;
   int         m_ptr;
   bit         m_lock;
   int         m_lock_id;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid   = 1'b0;
      m_data    = '0;
      m_id      = 0;
      m_last    = 1'b0;
      m_ptr     = 0;
      m_lock    = 1'b0;
      m_lock_id = 0;
   endtask

   // Requester that should own the stage this cycle, -1 if none
   function automatic int pick();
      if (m_lock) return m_lock_id;
      for (int k = 0; k < int'(N); k++) begin
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   // One clock: check req_ready before the edge, advance model, check outputs after
   task automatic cycle(output int acc);
      int           g;
      bit           ld;
      logic [N-1:0] er;
      acc = -1;
      #1;
      ld = !m_valid || out_ready;
      g  = pick();
      er = '0;
      if (rst_n && ld && g >= 0) er[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else if (g >= 0 && er[g] && req_valid[g]) begin
         acc     = g;
         m_valid = 1'b1;
         m_data  = req_data[g*W +: W];
         m_id    = g;
`ifdef STREAM_ARB_PKT_LOCK_EN
         m_last  = req_last[g];
         if (req_last[g]) begin
            m_lock = 1'b0;
            m_ptr  = (g + 1) % N;
         end else begin
            m_lock    = 1'b1;
            m_lock_id = g;
         end
`else
         m_ptr   = (g + 1) % N;
`endif
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         chk("out_data", 32'(out_data), 32'(m_data));
         chk("out_id", 32'(out_id), 32'(m_id));
`ifdef STREAM_ARB_PKT_LOCK_EN
         chk("out_last", 32'(out_last), 32'(m_last));
`endif
      end
   endtask

   initial begin
      int           acc;
      int           seq [5] = '{0, 1, 2, 3, 0};
      bit [N-1:0]   sv;
      logic [W-1:0] sd [N];
      bit           sl [N];

      // Reset held with every requester asserting valid
      model_reset();
      rst_n     = 1'b0;
      req_valid = '1;
      out_ready = 1'b1;
      for (int i = 0; i < int'(N); i++) req_data[i*W +: W] = W'(8'h10 + i);
`ifdef STREAM_ARB_PKT_LOCK_EN
      req_last  = '1;
`endif
      cycle(acc);
      cycle(acc);
      chk("rst_out_id", 32'(out_id), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      rst_n = 1'b1;

      // All valid, steady out_ready: ids rotate one beat per cycle
      for (int k = 0; k < 5; k++) begin
         cycle(acc);
         chk("rr_seq_id", 32'(out_id), 32'(seq[k]));
         chk("rr_seq_valid", 32'(out_valid), 32'd1);
      end

      // Lone requester 2
      req_valid = 4'b0100;
      req_data[2*W +: W] = 8'hA5;
      #1 chk("solo_ready", 32'(req_ready), 32'h4);
      cycle(acc);
      chk("solo_data", 32'(out_data), 32'hA5);
      chk("solo_id", 32'(out_id), 32'd2);

      // Backpressure holds the stage, then drain and reload together
      req_valid = '1;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle(acc);
         chk("bp_data", 32'(out_data), 32'hA5);
         chk("bp_id", 32'(out_id), 32'd2);
      end
      out_ready = 1'b1;
      cycle(acc);
      chk("bp_resume_id", 32'(out_id), 32'd3);
      chk("bp_resume_valid", 32'(out_valid), 32'd1);

      // Reset pulse with a held beat and ptr=3
      req_valid = 4'b0100;
      cycle(acc);
      #3 rst_n = 1'b0;
      #1 chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_ready", 32'(req_ready), 32'd0);
      model_reset();
      cycle(acc);
      rst_n     = 1'b1;
      req_valid = '1;
      cycle(acc);
      chk("post_rst_id", 32'(out_id), 32'd0);

`ifdef STREAM_ARB_PKT_LOCK_EN
      // Three-beat packet from req1 while req0 keeps asking
      req_valid = 4'b0011;
      req_last  = 4'b0001;
      cycle(acc);
      chk("pkt_id0", 32'(out_id), 32'd1);
      chk("pkt_last0", 32'(out_last), 32'd0);
      cycle(acc);
      chk("pkt_id1", 32'(out_id), 32'd1);
      chk("pkt_last1", 32'(out_last), 32'd0);
      req_last = 4'b0011;
      cycle(acc);
      chk("pkt_id2", 32'(out_id), 32'd1);
      chk("pkt_last2", 32'(out_last), 32'd1);
      cycle(acc);
      chk("pkt_after_id", 32'(out_id), 32'd0);
      req_last = '1;
`endif

      // Randomized traffic: sources hold valid/data until accepted
      sv = '0;
      for (int i = 0; i < int'(N); i++) begin
         sd[i] = '0;
         sl[i] = 1'b1;
      end
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < int'(N); i++) begin
            if (!sv[i] && $urandom_range(0, 2) == 0) begin
               sv[i] = 1'b1;
               sd[i] = W'($urandom);
               sl[i] = ($urandom_range(0, 2) == 0);
            end
            req_data[i*W +: W] = sd[i];
`ifdef STREAM_ARB_PKT_LOCK_EN
            req_last[i] = sl[i];
`endif
         end
         req_valid = sv;
         out_ready = ($urandom_range(0, 3) != 0);
         rst_n     = ($urandom_range(0, 499) != 0);
         cycle(acc);
         if (acc >= 0) sv[acc] = 1'b0;
         rst_n = 1'b1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
